// File: rtl/register_file_if.sv
// Write/read bus of the A09 register bank: one write port and two combinational read ports.
interface register_file_if #(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 3
);
  logic                 LD;
  logic [AddrWidth-1:0] WAddr;
  logic [DataWidth-1:0] DIn;
  logic [AddrWidth-1:0] RAddrA;
  logic [AddrWidth-1:0] RAddrB;
  logic [DataWidth-1:0] DOutA;
  logic [DataWidth-1:0] DOutB;

  modport master (
    output LD, WAddr, DIn, RAddrA, RAddrB,
    input  DOutA, DOutB
  );

  modport slave (
    input  LD, WAddr, DIn, RAddrA, RAddrB,
    output DOutA, DOutB
  );
endinterface

// File: rtl/register_file.sv
// A09 register bank: 2**AddrWidth x DataWidth, one write port, two combinational read
// ports, optional write-to-read forwarding and optional hard-wired zero register.
module register_file #(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 3,
  parameter int Bypass    = 1,
  parameter int ZeroReg   = 0
) (
  input  logic          Clk,
  input  logic          Reset,
  register_file_if.slave bus
);

  localparam int Depth = 2 ** AddrWidth;

  logic [DataWidth-1:0] regs [Depth];
  logic                 wr_en;
  logic [DataWidth-1:0] dout_a;
  logic [DataWidth-1:0] dout_b;

  // LD is active-low; a write aimed at a hard-wired zero register is simply dropped.
  assign wr_en = !bus.LD && !((ZeroReg != 0) && (bus.WAddr == '0));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      regs <= '{default: '0};
    end else if (wr_en) begin
      regs[bus.WAddr] <= bus.DIn;
    end
  end

  // Read mux for one port: array contents, then forwarding, then forced-zero overrides.
  function automatic logic [DataWidth-1:0] read_port(
    input logic [AddrWidth-1:0] raddr,
    input logic [DataWidth-1:0] stored
  );
    logic [DataWidth-1:0] val;
    val = stored;
    if ((Bypass != 0) && !bus.LD && (raddr == bus.WAddr)) begin
      val = bus.DIn;
    end
    if (Reset || ((ZeroReg != 0) && (raddr == '0))) begin
      val = '0;
    end
    return val;
  endfunction

  always_comb begin
    dout_a = read_port(bus.RAddrA, regs[bus.RAddrA]);
    dout_b = read_port(bus.RAddrB, regs[bus.RAddrB]);
  end

  assign bus.DOutA = dout_a;
  assign bus.DOutB = dout_b;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: three builds (forwarding, no forwarding, zero register)
// driven by one shared stimulus.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        ld;
  logic [2:0]  waddr;
  logic [15:0] din;
  logic [2:0]  ra;
  logic [2:0]  rb;

  int n_cmp;
  int n_mis;

  register_file_if #(.DataWidth(16), .AddrWidth(3)) if_b ();
  register_file_if #(.DataWidth(16), .AddrWidth(3)) if_n ();
  register_file_if #(.DataWidth(16), .AddrWidth(3)) if_z ();

  register_file #(.DataWidth(16), .AddrWidth(3), .Bypass(1), .ZeroReg(0)) dut_b (
    .Clk(clk), .Reset(rst), .bus(if_b.slave));
  register_file #(.DataWidth(16), .AddrWidth(3), .Bypass(0), .ZeroReg(0)) dut_n (
    .Clk(clk), .Reset(rst), .bus(if_n.slave));
  register_file #(.DataWidth(16), .AddrWidth(3), .Bypass(1), .ZeroReg(1)) dut_z (
    .Clk(clk), .Reset(rst), .bus(if_z.slave));

  assign if_b.LD = ld;  assign if_b.WAddr = waddr;  assign if_b.DIn = din;
  assign if_b.RAddrA = ra;  assign if_b.RAddrB = rb;
  assign if_n.LD = ld;  assign if_n.WAddr = waddr;  assign if_n.DIn = din;
  assign if_n.RAddrA = ra;  assign if_n.RAddrB = rb;
  assign if_z.LD = ld;  assign if_z.WAddr = waddr;  assign if_z.DIn = din;
  assign if_z.RAddrA = ra;  assign if_z.RAddrB = rb;

  initial clk = 1'b0;
  always #100 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b1; ld = 1'b1; waddr = 3'd0; din = 16'h0000; ra = 3'd0; rb = 3'd0;

    // 1: reset, then every register reads zero on both ports
    tick();
    ra = 3'd3; rb = 3'd4; #1;
    check_eq("rst_hold_a", if_b.DOutA, 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i); rb = 3'(7 - i); #1;
      check_eq($sformatf("rst_b_a%0d", i), if_b.DOutA, 16'h0000);
      check_eq($sformatf("rst_b_b%0d", i), if_b.DOutB, 16'h0000);
      check_eq($sformatf("rst_n_a%0d", i), if_n.DOutA, 16'h0000);
    end

    // 2: fill reg i with 00A0+i, sweep A up / B down
    for (int i = 0; i < 8; i++) begin
      ld = 1'b0; waddr = 3'(i); din = 16'h00A0 + 16'(i);
      tick();
    end
    ld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i); rb = 3'(7 - i); #1;
      check_eq($sformatf("fill_b_a%0d", i), if_b.DOutA, 16'h00A0 + 16'(i));
      check_eq($sformatf("fill_b_b%0d", 7 - i), if_b.DOutB, 16'h00A0 + 16'(7 - i));
      check_eq($sformatf("fill_n_a%0d", i), if_n.DOutA, 16'h00A0 + 16'(i));
      check_eq($sformatf("fill_z_a%0d", i), if_z.DOutA, (i == 0) ? 16'h0000 : 16'h00A0 + 16'(i));
    end
    ra = 3'd6; rb = 3'd6; #1;
    check_eq("same_addr_a", if_b.DOutA, 16'h00A6);
    check_eq("same_addr_b", if_b.DOutB, 16'h00A6);

    // 3: LD high holds reg 3 across three edges
    ld = 1'b1; waddr = 3'd3; din = 16'hFFFF; ra = 3'd3;
    tick(); tick(); tick();
    check_eq("hold_b", if_b.DOutA, 16'h00A3);
    check_eq("hold_n", if_n.DOutA, 16'h00A3);

    // 4: read-during-write, with and without forwarding
    ld = 1'b0; waddr = 3'd5; din = 16'h1234; ra = 3'd5; rb = 3'd6; #1;
    check_eq("byp_pre_a", if_b.DOutA, 16'h1234);
    check_eq("byp_pre_b", if_b.DOutB, 16'h00A6);
    check_eq("nobyp_pre_a", if_n.DOutA, 16'h00A5);
    check_eq("nobyp_pre_b", if_n.DOutB, 16'h00A6);
    tick();
    ld = 1'b1; #1;
    check_eq("byp_post_a", if_b.DOutA, 16'h1234);
    check_eq("nobyp_post_a", if_n.DOutA, 16'h1234);

    // 5: zero register ignores writes and never forwards
    ld = 1'b0; waddr = 3'd0; din = 16'hBEEF; ra = 3'd0; rb = 3'd1; #1;
    check_eq("zero_pre", if_z.DOutA, 16'h0000);
    check_eq("zero_ctrl_fwd", if_b.DOutA, 16'hBEEF);
    tick();
    ld = 1'b1; #1;
    check_eq("zero_post", if_z.DOutA, 16'h0000);
    check_eq("zero_ctrl_post", if_b.DOutA, 16'hBEEF);
    check_eq("zero_r1", if_z.DOutB, 16'h00A1);

    // 6: reset wins over a simultaneous write
    rst = 1'b1; ld = 1'b0; waddr = 3'd2; din = 16'h5555; ra = 3'd2; rb = 3'd5; #1;
    check_eq("rst_fwd_a", if_b.DOutA, 16'h0000);
    check_eq("rst_fwd_b", if_b.DOutB, 16'h0000);
    tick();
    rst = 1'b0; ld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i); rb = 3'(i); #1;
      check_eq($sformatf("rst2_b_a%0d", i), if_b.DOutA, 16'h0000);
      check_eq($sformatf("rst2_n_b%0d", i), if_n.DOutB, 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
